modexp_seq: RTL and testbench

- Sequences the shared combinational mod-29 multiplier `modmul` to compute m = base^exp mod 29 by left-to-right binary square-and-multiply.
- Exactly one `modmul` instance is time-multiplexed between squaring and multiply-by-base, one operation per clock.
- start/busy/done handshake; sits between a crypto-style requester and the modular datapath.

---
 rtl/modexp_seq_if.sv | 15 +
 rtl/modexp_seq.sv | 144 ++++++++++++++
 tb/tb_modexp_seq.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/modexp_seq_if.sv
// Request/response bundle between a modexp requester (master) and modexp_seq (slave).
// EXP_W must match the exponent width of the attached modexp_seq.
interface modexp_seq_if #(
  parameter int EXP_W = 5
);
  logic             start;
  logic [4:0]       base;
  logic [EXP_W-1:0] exp;
  logic             busy;
  logic             done;
  logic [4:0]       result;

  modport master (output start, base, exp, input busy, done, result);
  modport slave  (input start, base, exp, output busy, done, result);
endinterface

// File: rtl/modexp_seq.sv
// Left-to-right square-and-multiply base^exp mod 29 over one shared modmul instance.
// Define MODEXP_CONST_TIME_EN for data-independent latency (2*EXP_W ops per request).
module modmul (
  input  logic [4:0] a,
  input  logic [4:0] b,
  output logic [4:0] p
);
  logic [9:0] prod;
  logic [9:0] rem;

  always_comb begin
    prod = 10'(a) * 10'(b);
    rem  = prod % 10'd29;
    p    = rem[4:0];
  end
endmodule

module modexp_seq #(
  parameter int EXP_W = 5
) (
  input logic         clk,
  input logic         reset,
  modexp_seq_if.slave host
);
  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_W - 1);

  typedef enum logic [1:0] {IDLE, SQR, MUL, FIN} state_t;

  state_t           state_q, state_d;
  logic [4:0]       acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [4:0]       base_q, base_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [4:0]       result_q, result_d;

  logic [4:0] mm_a, mm_b, mm_p;
  logic       exp_bit;
  logic       last_bit;

  modmul u_modmul (
    .a (mm_a),
    .b (mm_b),
    .p (mm_p)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      acc_q    <= 5'd1;
      idx_q    <= IDX_TOP;
      base_q   <= '0;
      exp_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    exp_bit  = exp_q[idx_q];
    last_bit = (idx_q == '0);

    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    base_d   = base_q;
    exp_d    = exp_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (host.start) begin
          base_d  = host.base;
          exp_d   = host.exp;
          acc_d   = 5'd1;
          idx_d   = IDX_TOP;
          busy_d  = 1'b1;
          state_d = SQR;
        end
      end
      SQR: begin
        acc_d = mm_p;
`ifdef MODEXP_CONST_TIME_EN
        state_d = MUL;
`else
        if (exp_bit) begin
          state_d = MUL;
        end else if (last_bit) begin
          state_d = FIN;
        end else begin
          idx_d = idx_q - 1'b1;
        end
`endif
      end
      MUL: begin
`ifdef MODEXP_CONST_TIME_EN
        // The product is always formed; only the commit depends on the exponent bit.
        if (exp_bit) begin
          acc_d = mm_p;
        end
`else
        acc_d = mm_p;
`endif
        if (last_bit) begin
          state_d = FIN;
        end else begin
          idx_d   = idx_q - 1'b1;
          state_d = SQR;
        end
      end
      FIN: begin
        result_d = acc_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Squaring feeds acc on both inputs; multiply swaps in the latched base.
  always_comb begin
    mm_a = acc_q;
    mm_b = (state_q == MUL) ? base_q : acc_q;
  end

  assign host.busy   = busy_q;
  assign host.done   = done_q;
  assign host.result = result_q;
endmodule

// File: tb/tb_modexp_seq.sv
// Self-checking bench for modexp_seq: vector table, corner sequences, exhaustive sweep.
// Honours MODEXP_CONST_TIME_EN for the expected latency.
module tb_modexp_seq;
  localparam int EXP_W = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  modexp_seq_if #(.EXP_W(EXP_W)) bus ();

  modexp_seq #(.EXP_W(EXP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .host  (bus.slave)
  );

  typedef struct {
    int base;
    int exp;
    int res;
  } vec_t;

  typedef struct {
    int res;
    int lat;
    int busy_cyc;
  } sb_t;

  sb_t sb_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int powmod(input int b, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % 29;
    return r;
  endfunction

  // Edges from the start edge to the edge after which done is seen.
  function automatic int latency(input int e);
`ifdef MODEXP_CONST_TIME_EN
    return 2 * EXP_W + 1;
`else
    int pc = 0;
    for (int i = 0; i < EXP_W; i++) pc += (e >> i) & 1;
    return EXP_W + pc + 1;
`endif
  endfunction

  task automatic run_op(input int b, input int e, input bit scramble, input string tag);
    int  k = 0;
    int  busy_cnt = 0;
    bit  got = 0;
    sb_t exp_item;
    int  res_seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.base  = 5'(b);
    bus.exp   = EXP_W'(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    sb_q.push_back('{powmod(b, e), latency(e), latency(e)});
    while (!got && k < 200) begin
      if (bus.busy) busy_cnt++;
      check({tag, "_busy_done_excl"}, int'(bus.busy & bus.done), 0);
      if (bus.done) begin
        got = 1;
      end else begin
        if (scramble && k == 2) begin
          bus.base = 5'($urandom_range(0, 31));
          bus.exp  = EXP_W'($urandom_range(0, (1 << EXP_W) - 1));
        end
        @(posedge clk); #1;
        k++;
      end
    end
    exp_item = sb_q.pop_front();
    if (!got) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      res_seen = int'(bus.result);
      check({tag, "_result"}, res_seen, exp_item.res);
      check({tag, "_latency"}, k, exp_item.lat);
      check({tag, "_busy_cycles"}, busy_cnt, exp_item.busy_cyc);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, int'(bus.done), 0);
      check({tag, "_result_held"}, int'(bus.result), res_seen);
      $display("op %s base=%0d exp=%0d result=%0d latency=%0d", tag, b, e, res_seen, k);
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{2, 5, 3};
    vecs[1] = '{3, 28, 1};
    vecs[2] = '{31, 10, 9};
    vecs[3] = '{0, 0, 1};
    vecs[4] = '{17, 0, 1};
    vecs[5] = '{29, 7, 0};

    bus.start = 1'b0;
    bus.base  = '0;
    bus.exp   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_result", int'(bus.result), 0);
    @(negedge clk);
    reset = 1'b1;

    // Table vectors: expected values from the table, latency from the op count
    foreach (vecs[i]) begin
      run_op(vecs[i].base, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));
    end

    // Inputs changed while busy must not disturb the latched operands
    run_op(2, 1, 1'b1, "scramble");
    run_op(31, 10, 1'b1, "scramble2");

    // start held high: one computation per IDLE visit, single-cycle done pulses
    begin
      int dones = 0;
      int last_done = -1;
      int prev_done = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.base  = 5'd2;
      bus.exp   = EXP_W'(1);
      for (int c = 0; c < 60; c++) begin
        @(posedge clk); #1;
        if (bus.done) begin
          check("held_result", int'(bus.result), 2);
          check("held_single_pulse", prev_done, 0);
          if (last_done >= 0) check("held_period", c - last_done, latency(1) + 1);
          last_done = c;
          dones++;
          $display("op held base=2 exp=1 result=%0d cycle=%0d", bus.result, c);
        end
        prev_done = int'(bus.done);
      end
      check("held_count_ge3", int'(dones >= 3), 1);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2 * EXP_W + 4) @(posedge clk);
    end

    // Reset mid-computation (result nonzero beforehand)
    run_op(2, 5, 1'b0, "pre_reset");
    begin
      int late_dones = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.base  = 5'd2;
      bus.exp   = EXP_W'(31);
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      check("midrst_busy", int'(bus.busy), 0);
      check("midrst_done", int'(bus.done), 0);
      check("midrst_result", int'(bus.result), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk); #1;
        if (bus.done) late_dones++;
      end
      check("midrst_no_done", late_dones, 0);
      $display("op midreset base=2 exp=31 late_dones=%0d", late_dones);
    end

    // Exhaustive sweep against the repeated-multiply model
    for (int b = 0; b < 32; b++) begin
      for (int e = 0; e < (1 << EXP_W); e++) begin
        run_op(b, e, 1'b0, "sweep");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "simulation time limit exceeded");
  end
endmodule
